nes_controller_port: RTL and testbench



---
 rtl/nes_controller_port.sv | 191 +++++++++++++++++++
 tb/tb_nes_controller_port.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_port.sv
// nes_controller_port: CPU-side $4016/$4017 joypad responder plus a pad-side
// engine that polls a 4021-based NES controller and commits button snapshots.
// Optional build macro NES_CTRL_P2_EN adds a second controller
// (pad2_data / buttons2) served at $4017.
module nes_controller_port #(
    parameter int unsigned CLK_DIV     = 300,
    parameter int unsigned POLL_PERIOD = 833333
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_en,
    input  logic [15:0] addr,
    input  logic        r_en,
    input  logic [7:0]  w_data,
    output logic [7:0]  r_data,
    output logic        rd_hit,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic        pad1_data,
`ifdef NES_CTRL_P2_EN
    input  logic        pad2_data,
    output logic [7:0]  buttons2,
`endif
    output logic [7:0]  buttons1
);

    localparam int unsigned CNT_W = $clog2(POLL_PERIOD + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(POLL_PERIOD - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [15:0] ADDR_P1 = 16'h4016;
    localparam logic [15:0] ADDR_P2 = 16'h4017;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_LATCH,
        ST_CLK_HI,
        ST_CLK_LO,
        ST_COMMIT
    } poll_state_t;

    poll_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       cap1;
    logic             strobe;
    logic [7:0]       shift1;
`ifdef NES_CTRL_P2_EN
    logic [7:0]       cap2;
    logic [7:0]       shift2;
`endif

    // CPU access decode
    logic rd_p1_c;
    logic rd_p2_c;
    logic wr_p1_c;
    logic unused_w_data;

    assign rd_p1_c       = clock_en & r_en & (addr == ADDR_P1);
    assign rd_p2_c       = clock_en & r_en & (addr == ADDR_P2);
    assign wr_p1_c       = clock_en & ~r_en & (addr == ADDR_P1);
    assign unused_w_data = ^w_data[7:1];

    // Pad poll engine: latch pulse, 7 clock pulses, LSB-first capture, atomic commit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_WAIT;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            cap1      <= 8'h00;
            buttons1  <= 8'h00;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
`ifdef NES_CTRL_P2_EN
            cap2      <= 8'h00;
            buttons2  <= 8'h00;
`endif
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state     <= ST_LATCH;
                        cnt       <= '0;
                        pad_latch <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        cap1[0]   <= ~pad1_data;
`ifdef NES_CTRL_P2_EN
                        cap2[0]   <= ~pad2_data;
`endif
                        bit_idx   <= 3'd1;
                        state     <= ST_CLK_HI;
                        cnt       <= '0;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CLK_HI: begin
                    if (cnt == HALF_LAST) begin
                        state   <= ST_CLK_LO;
                        cnt     <= '0;
                        pad_clk <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CLK_LO: begin
                    if (cnt == HALF_LAST) begin
                        cap1[bit_idx] <= ~pad1_data;
`ifdef NES_CTRL_P2_EN
                        cap2[bit_idx] <= ~pad2_data;
`endif
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_COMMIT;
                        end else begin
                            state   <= ST_CLK_HI;
                            pad_clk <= 1'b1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    buttons1 <= cap1;
`ifdef NES_CTRL_P2_EN
                    buttons2 <= cap2;
`endif
                    state    <= ST_WAIT;
                    cnt      <= '0;
                end
                default: begin
                    state     <= ST_WAIT;
                    cnt       <= '0;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                end
            endcase
        end
    end

    // CPU side: strobe register, serial shift-out, registered read data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= 8'h00;
            rd_hit <= 1'b0;
            strobe <= 1'b0;
            shift1 <= 8'h00;
`ifdef NES_CTRL_P2_EN
            shift2 <= 8'h00;
`endif
        end else begin
            rd_hit <= rd_p1_c | rd_p2_c;
            if (clock_en) begin
                if (wr_p1_c) begin
                    strobe <= w_data[0];
                end
                // Reload uses the current (pre-write) strobe and pre-commit buttons
                if (strobe) begin
                    shift1 <= buttons1;
                end else if (rd_p1_c) begin
                    shift1 <= {1'b1, shift1[7:1]};
                end
`ifdef NES_CTRL_P2_EN
                if (strobe) begin
                    shift2 <= buttons2;
                end else if (rd_p2_c) begin
                    shift2 <= {1'b1, shift2[7:1]};
                end
`endif
                if (rd_p1_c) begin
                    r_data <= {7'b0100000, strobe ? buttons1[0] : shift1[0]};
                end else if (rd_p2_c) begin
`ifdef NES_CTRL_P2_EN
                    r_data <= {7'b0100000, strobe ? buttons2[0] : shift2[0]};
`else
                    r_data <= 8'h40;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_nes_controller_port.sv
// Self-checking bench for nes_controller_port: behavioural 4021 pad model,
// read-data scoreboard, and one task per scenario.
module tb_nes_controller_port;

    localparam int unsigned D = 3;
    localparam int unsigned P = 120;
    localparam int unsigned POLL_CYCLES = 16 * D + 1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clock_en = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        r_en = 1'b0;
    logic [7:0]  w_data = 8'h00;
    logic [7:0]  r_data;
    logic        rd_hit;
    logic        pad_latch;
    logic        pad_clk;
    logic        pad1_data;
    logic [7:0]  buttons1;
`ifdef NES_CTRL_P2_EN
    logic        pad2_data;
    logic [7:0]  buttons2;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    nes_controller_port #(.CLK_DIV(D), .POLL_PERIOD(P)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clock_en  (clock_en),
        .addr      (addr),
        .r_en      (r_en),
        .w_data    (w_data),
        .r_data    (r_data),
        .rd_hit    (rd_hit),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .pad1_data (pad1_data),
`ifdef NES_CTRL_P2_EN
        .pad2_data (pad2_data),
        .buttons2  (buttons2),
`endif
        .buttons1  (buttons1)
    );

    // 4021 model: parallel load on latch rise, shift on pad clock rise, active-low out
    logic [7:0] pressed1 = 8'hFF;
    logic [7:0] sreg1 = 8'h00;
    always @(posedge pad_latch) sreg1 <= ~pressed1;
    always @(posedge pad_clk)   sreg1 <= {1'b1, sreg1[7:1]};
    assign pad1_data = sreg1[0];
`ifdef NES_CTRL_P2_EN
    logic [7:0] pressed2 = 8'h00;
    logic [7:0] sreg2 = 8'hFF;
    always @(posedge pad_latch) sreg2 <= ~pressed2;
    always @(posedge pad_clk)   sreg2 <= {1'b1, sreg2[7:1]};
    assign pad2_data = sreg2[0];
`endif

    // Scoreboard: every read-hit cycle pops one expected value
    always @(negedge clock) begin
        if (reset_n && rd_hit) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: rd_hit with no pending read, r_data=%02h", r_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (r_data !== e) begin
                    fails++;
                    $display("FAIL rd_data: got %02h expected %02h", r_data, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        addr = 16'h0000; r_en = 1'b0; w_data = 8'h00; clock_en = 1'b1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        addr = a; r_en = 1'b0; w_data = d; clock_en = 1'b1;
        @(negedge clock);
        drive_idle();
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] e);
        @(negedge clock);
        addr = a; r_en = 1'b1; clock_en = 1'b1;
        exp_q.push_back(e);
        @(negedge clock);
        drive_idle();
    endtask

    function automatic logic [7:0] bit_byte(input logic [7:0] v, input int i);
        return v[i] ? 8'h41 : 8'h40;
    endfunction

    // Waits for a fresh latch pulse, then past the commit of that poll
    task automatic wait_commit();
        int n;
        n = 0;
        while (pad_latch === 1'b1 && n < 4 * P) begin @(negedge clock); n++; end
        while (pad_latch !== 1'b1 && n < 4 * P) begin @(negedge clock); n++; end
        tests++;
        if (pad_latch !== 1'b1) begin
            fails++;
            $display("FAIL poll_timeout: no latch pulse within %0d cycles", 4 * P);
        end
        repeat (16 * D + 2) @(negedge clock);
    endtask

    task automatic test_reset();
        int n;
        pressed1 = 8'hFF;
        repeat (3) @(negedge clock);
        tests++;
        if (r_data !== 8'h00 || rd_hit !== 1'b0 || buttons1 !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: r_data=%02h rd_hit=%b buttons1=%02h expected 00/0/00",
                     r_data, rd_hit, buttons1);
        end
        tests++;
        if (pad_latch !== 1'b0 || pad_clk !== 1'b0) begin
            fails++;
            $display("FAIL reset_pad: latch=%b clk=%b expected 0/0", pad_latch, pad_clk);
        end
        reset_n = 1'b1;
        n = 0;
        while (buttons1 === 8'h00 && n < 2 * (P + POLL_CYCLES)) begin
            @(posedge clock);
            n++;
            #1;
        end
        tests++;
        if (n != int'(P + POLL_CYCLES)) begin
            fails++;
            $display("FAIL first_commit_time: got %0d cycles expected %0d", n, P + POLL_CYCLES);
        end
        tests++;
        if (buttons1 !== 8'hFF) begin
            fails++;
            $display("FAIL first_commit_value: got %02h expected ff", buttons1);
        end
        @(negedge clock);
        drive_idle();
    endtask

    task automatic test_start_readout();
        pressed1 = 8'h08;
        wait_commit();
        tests++;
        if (buttons1 !== 8'h08) begin
            fails++;
            $display("FAIL start_buttons: got %02h expected 08", buttons1);
        end
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 8; i++) cpu_read(16'h4016, bit_byte(pressed1, i));
        cpu_read(16'h4016, 8'h41);
        cpu_read(16'h4016, 8'h41);
    endtask

    task automatic test_strobe_hold();
        pressed1 = 8'h01;
        wait_commit();
        tests++;
        if (buttons1 !== 8'h01) begin
            fails++;
            $display("FAIL strobe_buttons: got %02h expected 01", buttons1);
        end
        cpu_write(16'h4016, 8'h01);
        for (int i = 0; i < 3; i++) cpu_read(16'h4016, 8'h41);
        cpu_write(16'h4016, 8'h00);
        cpu_read(16'h4016, 8'h41);
        cpu_read(16'h4016, 8'h40);
    endtask

    task automatic test_clock_en();
        pressed1 = 8'h05;
        wait_commit();
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        cpu_read(16'h4016, 8'h41);
        @(negedge clock);
        addr = 16'h4016; r_en = 1'b1; clock_en = 1'b0;
        @(negedge clock);
        tests++;
        if (rd_hit !== 1'b0 || r_data !== 8'h41) begin
            fails++;
            $display("FAIL ce_low_read: rd_hit=%b r_data=%02h expected 0/41", rd_hit, r_data);
        end
        drive_idle();
        cpu_read(16'h4016, 8'h40);
        cpu_read(16'h4016, 8'h41);
`ifndef NES_CTRL_P2_EN
        cpu_read(16'h4017, 8'h40);
`endif
    endtask

    task automatic test_back_to_back();
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        cpu_write(16'h4017, 8'h01);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            addr = 16'h4016; r_en = 1'b1; clock_en = 1'b1;
            exp_q.push_back(bit_byte(pressed1, i));
        end
        @(negedge clock);
        drive_idle();
        cpu_read(16'h4016, 8'h41);
    endtask

    task automatic test_reset_midpoll();
        int n;
        int falls;
        logic prev;
        pressed1 = 8'h3C;
        n = 0;
        while (pad_latch === 1'b1 && n < 4 * P) begin @(negedge clock); n++; end
        while (pad_latch !== 1'b1 && n < 4 * P) begin @(negedge clock); n++; end
        falls = 0;
        prev = pad_clk;
        while (falls < 4 && n < 4 * P) begin
            @(negedge clock);
            n++;
            if (prev === 1'b1 && pad_clk === 1'b0) falls++;
            prev = pad_clk;
        end
        tests++;
        if (falls != 4) begin
            fails++;
            $display("FAIL midpoll_reach: saw %0d pad_clk falls expected 4", falls);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (pad_clk !== 1'b0 || pad_latch !== 1'b0) begin
            fails++;
            $display("FAIL midpoll_pads: clk=%b latch=%b expected 0/0", pad_clk, pad_latch);
        end
        tests++;
        if (buttons1 !== 8'h00 || r_data !== 8'h00) begin
            fails++;
            $display("FAIL midpoll_regs: buttons1=%02h r_data=%02h expected 00/00", buttons1, r_data);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_commit();
        tests++;
        if (buttons1 !== 8'h3C) begin
            fails++;
            $display("FAIL midpoll_recover: got %02h expected 3c", buttons1);
        end
    endtask

`ifdef NES_CTRL_P2_EN
    task automatic test_p2();
        pressed2 = 8'h81;
        wait_commit();
        tests++;
        if (buttons2 !== 8'h81 || buttons1 !== pressed1) begin
            fails++;
            $display("FAIL p2_buttons: b2=%02h b1=%02h expected 81/%02h", buttons2, buttons1, pressed1);
        end
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 8; i++) cpu_read(16'h4017, bit_byte(pressed2, i));
        cpu_read(16'h4016, bit_byte(pressed1, 0));
    endtask
`endif

    initial begin
        test_reset();
        test_start_readout();
        test_strobe_hold();
        test_clock_en();
        test_back_to_back();
        test_reset_midpoll();
`ifdef NES_CTRL_P2_EN
        test_p2();
`endif
        repeat (3) @(negedge clock);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d reads never answered, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
